// File: rtl/nf10_axis_pkt_gen_if.sv
// AXI4-Stream transmit bundle (NetFPGA flavour: tstrb byte lanes, tuser metadata).
`timescale 1ns/1ps

interface nf10_axis_pkt_gen_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned USER_W = 128
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tstrb;
    logic [USER_W-1:0]   tuser;
    logic                tvalid;
    logic                tready;
    logic                tlast;

    modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/nf10_axis_pkt_gen.sv
// Deterministic AXI4-Stream packet generator for the 10G loopback test.
// Beat k of packet n carries {n, k}; tuser holds length and src/dst ports.
`timescale 1ns/1ps

module nf10_axis_pkt_gen #(
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 64,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
    parameter logic [7:0]  C_SRC_PORT           = 8'h00,
    parameter logic [7:0]  C_DST_PORT           = 8'h04
) (
    input  logic                      axi_aclk,
    input  logic                      axi_reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic [15:0]               pkt_len,
    input  logic [31:0]               pkt_count,
    input  logic [7:0]                ifg_cycles,
    nf10_axis_pkt_gen_if.master       m_axis,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               pkts_sent
);
    localparam int unsigned STRB_W  = C_M_AXIS_DATA_WIDTH / 8;
    localparam int unsigned MIN_LEN = 60;
    localparam int unsigned MAX_LEN = 1518;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t                            state_q, state_d;
    logic [15:0]                       last_idx_q, last_idx_d;
    logic [STRB_W-1:0]                 last_strb_q, last_strb_d;
    logic [31:0]                       count_q, count_d;
    logic [7:0]                        ifg_q, ifg_d;
    logic [7:0]                        gap_q, gap_d;
    logic [31:0]                       seq_q, seq_d;
    logic [31:0]                       beat_q, beat_d;
    logic [31:0]                       pkts_q, pkts_d;
    logic                              stop_pend_q, stop_pend_d;
    logic                              busy_q, busy_d;
    logic                              done_q, done_d;
    logic                              tvalid_q, tvalid_d;
    logic                              tlast_q, tlast_d;
    logic [C_M_AXIS_DATA_WIDTH-1:0]    tdata_q, tdata_d;
    logic [STRB_W-1:0]                 tstrb_q, tstrb_d;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]   tuser_q, tuser_d;

    logic [15:0] clen_c;
    logic [15:0] last_idx_c;
    logic [7:0]  last_strb_c;
    logic        hs_c;
    logic        last_next_c;
    logic        run_end_c;

    // Length clamp and per-packet constants derived from the requested length
    assign clen_c      = (pkt_len < 16'(MIN_LEN)) ? 16'(MIN_LEN) :
                         (pkt_len > 16'(MAX_LEN)) ? 16'(MAX_LEN) : pkt_len;
    assign last_idx_c  = ((clen_c + 16'd7) >> 3) - 16'd1;
    assign last_strb_c = (clen_c[2:0] == 3'd0) ? 8'hFF : ~(8'hFF << clen_c[2:0]);

    assign hs_c        = tvalid_q & m_axis.tready;
    assign last_next_c = (beat_q + 32'd1) == 32'(last_idx_q);
    assign run_end_c   = stop_pend_q | stop |
                         ((count_q != 32'd0) && ((pkts_q + 32'd1) == count_q));

    always_comb begin
        state_d     = state_q;
        last_idx_d  = last_idx_q;
        last_strb_d = last_strb_q;
        count_d     = count_q;
        ifg_d       = ifg_q;
        gap_d       = gap_q;
        seq_d       = seq_q;
        beat_d      = beat_q;
        pkts_d      = pkts_q;
        stop_pend_d = stop_pend_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tdata_d     = tdata_q;
        tstrb_d     = tstrb_q;
        tuser_d     = tuser_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SEND;
                    last_idx_d  = last_idx_c;
                    last_strb_d = STRB_W'(last_strb_c);
                    count_d     = pkt_count;
                    ifg_d       = ifg_cycles;
                    seq_d       = 32'd0;
                    beat_d      = 32'd0;
                    pkts_d      = 32'd0;
                    stop_pend_d = 1'b0;
                    busy_d      = 1'b1;
                    tvalid_d    = 1'b1;
                    tlast_d     = 1'b0;
                    tdata_d     = '0;
                    tstrb_d     = '1;
                    tuser_d     = C_M_AXIS_TUSER_WIDTH'({C_DST_PORT, C_SRC_PORT, clen_c});
                end
            end
            SEND: begin
                stop_pend_d = stop_pend_q | stop;
                if (hs_c && tlast_q) begin
                    pkts_d  = pkts_q + 32'd1;
                    seq_d   = seq_q + 32'd1;
                    beat_d  = 32'd0;
                    tlast_d = 1'b0;
                    if (run_end_c) begin
                        state_d  = IDLE;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        tvalid_d = 1'b0;
                    end else if (ifg_q == 8'd0) begin
                        tdata_d = C_M_AXIS_DATA_WIDTH'({seq_q + 32'd1, 32'd0});
                        tstrb_d = '1;
                    end else begin
                        state_d  = GAP;
                        gap_d    = ifg_q;
                        tvalid_d = 1'b0;
                    end
                end else if (hs_c) begin
                    beat_d  = beat_q + 32'd1;
                    tdata_d = C_M_AXIS_DATA_WIDTH'({seq_q, beat_q + 32'd1});
                    tlast_d = last_next_c;
                    tstrb_d = last_next_c ? last_strb_q : '1;
                end
            end
            GAP: begin
                // A stop in the gap ends the run at once; no packet is in flight
                if (stop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (gap_q <= 8'd1) begin
                    state_d  = SEND;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    tdata_d  = C_M_AXIS_DATA_WIDTH'({seq_q, 32'd0});
                    tstrb_d  = '1;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_q     <= IDLE;
            last_idx_q  <= '0;
            last_strb_q <= '0;
            count_q     <= '0;
            ifg_q       <= '0;
            gap_q       <= '0;
            seq_q       <= '0;
            beat_q      <= '0;
            pkts_q      <= '0;
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
            tstrb_q     <= '0;
            tuser_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_idx_q  <= last_idx_d;
            last_strb_q <= last_strb_d;
            count_q     <= count_d;
            ifg_q       <= ifg_d;
            gap_q       <= gap_d;
            seq_q       <= seq_d;
            beat_q      <= beat_d;
            pkts_q      <= pkts_d;
            stop_pend_q <= stop_pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tdata_q     <= tdata_d;
            tstrb_q     <= tstrb_d;
            tuser_q     <= tuser_d;
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tstrb  = tstrb_q;
    assign m_axis.tuser  = tuser_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pkts_sent     = pkts_q;
endmodule

// File: tb/tb_nf10_axis_pkt_gen.sv
// Scoreboard bench for nf10_axis_pkt_gen: expected beats are queued at start,
// a negedge monitor pops and compares every handshake.
`timescale 1ns/1ps

module tb_nf10_axis_pkt_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] pkt_len = '0;
    logic [31:0] pkt_count = '0;
    logic [7:0]  ifg_cycles = '0;
    logic        busy, done;
    logic [31:0] pkts_sent;

    nf10_axis_pkt_gen_if axis ();

    nf10_axis_pkt_gen dut (
        .axi_aclk   (clk),
        .axi_reset  (rst),
        .start      (start),
        .stop       (stop),
        .pkt_len    (pkt_len),
        .pkt_count  (pkt_count),
        .ifg_cycles (ifg_cycles),
        .m_axis     (axis),
        .busy       (busy),
        .done       (done),
        .pkts_sent  (pkts_sent)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]  data;
        logic [7:0]   strb;
        logic         last;
        logic [127:0] user;
        int           k;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    pops = 0;
    int    cyc = 0;
    int    last_hs_cyc = 0;
    int    idle_cnt = 0;
    int    last_gap = -1;
    bit    in_gap = 0;
    int    tready_mode = 1;   // 0 low, 1 high, 2 random

    always @(posedge clk) cyc++;

    initial forever begin
        case (tready_mode)
            0:       axis.tready = 1'b0;
            2:       axis.tready = 1'($urandom_range(0, 1));
            default: axis.tready = 1'b1;
        endcase
        @(posedge clk);
        #2;
    end

    // Handshake monitor: scoreboard compare, stall stability, gap measurement
    bit           prev_stall = 0;
    logic [63:0]  s_data;
    logic [7:0]   s_strb;
    logic [127:0] s_user;
    logic         s_last;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                total++;
                if (axis.tvalid !== 1'b1 || axis.tdata !== s_data || axis.tstrb !== s_strb ||
                    axis.tuser !== s_user || axis.tlast !== s_last) begin
                    bad++;
                    $display("FAIL stall_hold: got valid=%b data=%h strb=%h last=%b, want valid=1 data=%h strb=%h last=%b",
                             axis.tvalid, axis.tdata, axis.tstrb, axis.tlast, s_data, s_strb, s_last);
                end
            end
            if (axis.tvalid && axis.tready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: got data=%h last=%b, want no beat", axis.tdata, axis.tlast);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    if (axis.tdata !== e.data || axis.tstrb !== e.strb ||
                        axis.tlast !== e.last || axis.tuser !== e.user) begin
                        bad++;
                        $display("FAIL beat: got data=%h strb=%h last=%b user=%h, want data=%h strb=%h last=%b user=%h",
                                 axis.tdata, axis.tstrb, axis.tlast, axis.tuser, e.data, e.strb, e.last, e.user);
                    end
                    if (in_gap && e.k == 0) begin
                        last_gap = idle_cnt;
                        in_gap = 0;
                    end
                end
                if (axis.tlast) begin
                    in_gap = 1;
                    idle_cnt = 0;
                end
                pops++;
                last_hs_cyc = cyc;
            end else if (!axis.tvalid && in_gap) begin
                idle_cnt++;
            end
            prev_stall = axis.tvalid && !axis.tready;
            s_data = axis.tdata; s_strb = axis.tstrb; s_user = axis.tuser; s_last = axis.tlast;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish, want finish within 2ms");
        $fatal(1, "watchdog");
    end

    function automatic int clamp(int l);
        return (l < 60) ? 60 : (l > 1518) ? 1518 : l;
    endfunction

    task automatic push_pkts(input int len, input int cnt);
        int l, nb;
        beat_t b;
        l  = clamp(len);
        nb = (l + 7) / 8;
        for (int n = 0; n < cnt; n++) begin
            for (int k = 0; k < nb; k++) begin
                b.data = {32'(n), 32'(k)};
                b.last = (k == nb - 1);
                b.strb = (b.last && (l % 8) != 0) ? 8'((1 << (l % 8)) - 1) : 8'hFF;
                b.user = {96'd0, 8'h04, 8'h00, 16'(l)};
                b.k    = k;
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int len, input int cnt, input int ifg);
        pkt_len    = 16'(len);
        pkt_count  = 32'(cnt);
        ifg_cycles = 8'(ifg);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_pops(input int target);
        for (int i = 0; i < 2000 && pops < target; i++) tick();
    endtask

    task automatic wait_done(input int max, output bit ok, output int when);
        ok = 0;
        when = -1;
        for (int i = 0; i < max; i++) begin
            tick();
            if (done) begin
                ok = 1;
                when = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if (axis.tvalid !== 0 || axis.tlast !== 0 || axis.tdata !== 0 || axis.tstrb !== 0 ||
            axis.tuser !== 0 || busy !== 0 || done !== 0 || pkts_sent !== 0) begin
            bad++;
            $display("FAIL reset_state: got valid=%b last=%b data=%h strb=%h busy=%b done=%b sent=%0d, want all 0",
                     axis.tvalid, axis.tlast, axis.tdata, axis.tstrb, busy, done, pkts_sent);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_min_packet();
        int p0, when;
        bit ok;
        p0 = pops;
        push_pkts(60, 1);
        start_run(60, 1, 0);
        total++;
        if (busy !== 1 || axis.tvalid !== 1 || axis.tdata !== 64'd0) begin
            bad++;
            $display("FAIL start_latency: got busy=%b valid=%b data=%h, want 1 1 0", busy, axis.tvalid, axis.tdata);
        end
        wait_done(100, ok, when);
        total++;
        if (!ok || when !== last_hs_cyc + 1) begin
            bad++;
            $display("FAIL min_done_timing: got ok=%b done_cyc=%0d, want done at %0d", ok, when, last_hs_cyc + 1);
        end
        total++;
        if (pops - p0 !== 8 || pkts_sent !== 1 || busy !== 0) begin
            bad++;
            $display("FAIL min_count: got beats=%0d sent=%0d busy=%b, want 8 1 0", pops - p0, pkts_sent, busy);
        end
        tick();
        total++;
        if (done !== 0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL min_done_pulse: got done=%b left=%0d, want 0 0", done, exp_q.size());
        end
    endtask

    task automatic test_clamp();
        int lens[3] = '{10, 2000, 64};
        int nbs[3]  = '{8, 190, 8};
        int p0, when;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            p0 = pops;
            push_pkts(lens[i], 1);
            start_run(lens[i], 1, 0);
            wait_done(400, ok, when);
            total++;
            if (!ok || pops - p0 !== nbs[i] || exp_q.size() != 0) begin
                bad++;
                $display("FAIL clamp_len%0d: got done=%b beats=%0d left=%0d, want 1 %0d 0",
                         lens[i], ok, pops - p0, exp_q.size(), nbs[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_pressure();
        int p0, when;
        bit ok;
        p0 = pops;
        tready_mode = 2;
        push_pkts(100, 3);
        start_run(100, 3, 0);
        wait_done(1000, ok, when);
        total++;
        if (!ok || pkts_sent !== 3 || pops - p0 !== 39 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL back_pressure: got done=%b sent=%0d beats=%0d left=%0d, want 1 3 39 0",
                     ok, pkts_sent, pops - p0, exp_q.size());
        end
        tready_mode = 1;
        tick();
    endtask

    task automatic test_gap();
        int when;
        bit ok;
        last_gap = -1;
        push_pkts(60, 2);
        start_run(60, 2, 5);
        wait_done(200, ok, when);
        total++;
        if (!ok || last_gap !== 5 || pkts_sent !== 2 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL gap: got done=%b idle=%0d sent=%0d, want 1 5 2", ok, last_gap, pkts_sent);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int when, c0;
        bit ok;
        last_gap = -1;
        push_pkts(60, 3);
        start_run(60, 3, 0);
        c0 = cyc;
        wait_done(200, ok, when);
        total++;
        if (!ok || last_gap !== 0 || last_hs_cyc !== c0 + 23 || pkts_sent !== 3) begin
            bad++;
            $display("FAIL back_to_back: got done=%b idle=%0d last_cyc=%0d sent=%0d, want 1 0 %0d 3",
                     ok, last_gap, last_hs_cyc, pkts_sent, c0 + 23);
        end
        tick();
    endtask

    task automatic test_stop();
        int p0, when;
        bit ok;
        p0 = pops;
        push_pkts(60, 5);
        start_run(60, 0, 0);
        wait_pops(p0 + 20);
        pkt_len = 16'd200;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_pops(p0 + 34);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done(200, ok, when);
        total++;
        if (!ok || pkts_sent !== 5 || exp_q.size() != 0 || busy !== 0) begin
            bad++;
            $display("FAIL stop_send: got done=%b sent=%0d left=%0d busy=%b, want 1 5 0 0",
                     ok, pkts_sent, exp_q.size(), busy);
        end
        tick();
        p0 = pops;
        push_pkts(60, 1);
        start_run(60, 0, 10);
        wait_pops(p0 + 8);
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        total++;
        if (done !== 1 || busy !== 0 || pkts_sent !== 1 || axis.tvalid !== 0) begin
            bad++;
            $display("FAIL stop_gap: got done=%b busy=%b sent=%0d valid=%b, want 1 0 1 0",
                     done, busy, pkts_sent, axis.tvalid);
        end
        repeat (15) tick();
        total++;
        if (axis.tvalid !== 0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL stop_gap_idle: got valid=%b left=%0d, want 0 0", axis.tvalid, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_packet();
        int p0, when;
        bit ok;
        p0 = pops;
        push_pkts(60, 2);
        start_run(60, 0, 0);
        wait_pops(p0 + 11);
        rst = 1'b1;
        tready_mode = 0;
        tick();
        total++;
        if (axis.tvalid !== 0 || axis.tlast !== 0 || axis.tdata !== 0 || axis.tstrb !== 0 ||
            axis.tuser !== 0 || busy !== 0 || done !== 0 || pkts_sent !== 0) begin
            bad++;
            $display("FAIL reset_mid: got valid=%b last=%b data=%h strb=%h busy=%b done=%b sent=%0d, want all 0",
                     axis.tvalid, axis.tlast, axis.tdata, axis.tstrb, busy, done, pkts_sent);
        end
        rst = 1'b0;
        exp_q.delete();
        tready_mode = 1;
        tick();
        push_pkts(60, 1);
        start_run(60, 1, 0);
        wait_done(100, ok, when);
        total++;
        if (!ok || pkts_sent !== 1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL reset_restart: got done=%b sent=%0d left=%0d, want 1 1 0", ok, pkts_sent, exp_q.size());
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_min_packet();
        test_clamp();
        test_back_pressure();
        test_gap();
        test_back_to_back();
        test_stop();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nf10_axis_pkt_gen.md
# nf10_axis_pkt_gen

Synchronous AXI4-Stream packet generator that drives the 64-bit slave (transmit) port of a 10G interface in the loopback test design. It emits NetFPGA-format packets: metadata in tuser, little-endian byte strobes in tstrb. Packets carry a deterministic payload that a downstream checker can verify after the packets return through the loopback path.

## Interface
Parameters:
- C_M_AXIS_DATA_WIDTH, 64, stream data width; only 64 is supported.
- C_M_AXIS_TUSER_WIDTH, 128, sideband width.
- C_SRC_PORT, 8'h00, value placed in tuser[23:16].
- C_DST_PORT, 8'h04, one-hot egress port placed in tuser[31:24].

Ports:
- axi_aclk  in  1  single clock; all logic on its rising edge.
- axi_reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run (ignored while busy).
- stop  in  1  one-cycle pulse; ends the run at the next packet boundary.
- pkt_len  in  16  packet length in bytes, sampled at start.
- pkt_count  in  32  packets per run, sampled at start; 0 = continuous.
- ifg_cycles  in  8  idle cycles between packets, sampled at start.
- m_axis_tdata  out  64  beat data.
- m_axis_tstrb  out  8  byte-lane strobes; bit i = byte i.
- m_axis_tuser  out  128  metadata.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tlast  out  1  last beat of packet.
- busy  out  1  high from the cycle after start until the run ends.
- done  out  1  one-cycle pulse when the run ends.
- pkts_sent  out  32  packets fully handshaken in the current run.

## Operation
- FSM states: IDLE, SEND, GAP.
- IDLE
  - On start: latch pkt_len, pkt_count and ifg_cycles.
  - Clear pkts_sent, sequence number and beat index.
  - Go to SEND.
- Length clamp: latched lengths below 60 become 60; above 1518 become 1518.
- Beats per packet: ceil(len/8).
- Beat k of packet n: tdata = {n[31:0], k[31:0]}, with n and k counting from 0.
- Strobes
  - Non-last beats: tstrb = 8'hFF.
  - Last beat: the low (len mod 8) bits set, or 8'hFF when len mod 8 = 0.
- tuser: [15:0] = clamped length, [23:16] = C_SRC_PORT, [31:24] = C_DST_PORT, [127:32] = 0. Constant for the whole packet.
- SEND
  - tvalid = 1 throughout.
  - The beat advances only on tvalid & tready.
  - tlast is asserted on the final beat.
- On last-beat handshake, in priority order:
  1. Increment pkts_sent and the sequence number.
  2. If stop is pending, or pkt_count ≠ 0 and pkts_sent reaches pkt_count: go to IDLE and pulse done.
  3. Otherwise, if ifg_cycles = 0: start the next packet on the next cycle.
  4. Otherwise: go to GAP with the counter loaded to ifg_cycles.
- GAP: tvalid = 0. Decrement each cycle; on the cycle the counter reaches 1, go to SEND.
- stop handling
  - In SEND: sets a pending flag; the packet in flight always completes and is never truncated.
  - In GAP: go to IDLE immediately and pulse done.
  - In IDLE: ignored.
- start while busy: ignored.
- start and stop in the same IDLE cycle: start proceeds and stop is ignored.
- Continuous mode: the sequence number and pkts_sent wrap modulo 2^32.
- Reset
  - Applies in any state, including mid-packet, with no tlast emitted.
  - Next cycle: FSM = IDLE and every output = 0 (tvalid, tlast, tdata, tstrb, tuser, busy, done, pkts_sent).

## Timing
- All outputs are registered.
- start sampled at cycle T → tvalid, first beat, and busy all high at T+1.
- AXI stability: while tvalid & !tready, tdata, tstrb, tuser and tlast hold their values. tvalid never drops before its handshake.
- ifg_cycles = 0 with tready held high: one beat per cycle with no bubbles across packet boundaries.
- ifg_cycles = G > 0: exactly G cycles of tvalid = 0 between the last-beat handshake and the next first beat.
- Run end
  - busy falls in the cycle after the final handshake.
  - done pulses in that same cycle.
  - pkts_sent is final in that same cycle.
- tready is not used combinationally to form any output.

## Test plan
- Minimum packet: pkt_len = 60, pkt_count = 1, ifg = 0, tready = 1.
  - 8 beats; beat 7 has tlast = 1 and tstrb = 8'h0F.
  - tuser[15:0] = 60, tuser[31:24] = 8'h04.
  - done pulses 1 cycle after the last beat; pkts_sent = 1.
- Clamping and strobes:
  - pkt_len = 10 → 60 bytes, 8 beats.
  - pkt_len = 2000 → 1518 bytes, 190 beats, last tstrb = 8'h3F.
  - pkt_len = 64 → last tstrb = 8'hFF.
- Back-pressure: pkt_len = 100, count = 3, random tready at 50%.
  - Data is stable under stall and beats are never skipped or duplicated.
  - Payloads are {n, k} for n = 0..2, k = 0..12; pkts_sent = 3.
- Gap: ifg = 5, count = 2, tready = 1.
  - Exactly 5 idle cycles between packet 0 tlast and packet 1 beat 0.
- stop: continuous run (count = 0).
  - stop mid-packet 4 → packet 4 completes, done pulses, pkts_sent = 5.
  - stop during GAP → immediate done.
  - start while busy → no effect.
- Reset mid-packet (beat 3): next cycle all outputs = 0 with no tlast emitted; a fresh start restarts with sequence number 0.
